alu_seq_module: RTL and testbench
=================================

// Module: alu_seq_module
// PURPOSE
//  Parametrised successor to the 8-bit add/sub ALU of the SAP-style CPU.
//  - Registered result and flag (Z/C/N/V) registers; tri-state drive onto the shared bus.
//  - Eight ops: ADD, SUB, AND, OR and XOR in one cycle; SHL, SHR and MUL over several cycles.
//  - Uses a start/busy/done handshake so the controller sequencer can stall on long ops.
// PARAMETERS
//  WIDTH   8  datapath/bus width in bits; legal range 4..32
//  MUL_EN  1  1 = iterative shift-add multiplier present; 0 = op 111 returns 0 in one cycle
// PORTS
//  clk    in     1      system clock, rising edge
//  rst    in     1      asynchronous, active-low reset
//  start  in     1      op request; sampled only in IDLE
//  op     in     3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//  fe     in     1      flag enable; sampled with start; 0 = flags held at completion
//  a      in     WIDTH  operand A (A register)
//  b      in     WIDTH  operand B (B register)
//  oe     in     1      drive result register onto bus
//  busy   out    1      multi-cycle op in progress
//  done   out    1      one-cycle pulse: result/flags updated this cycle
//  zf     out    1      zero flag
//  cf     out    1      carry / borrow / shifted-out / mul-overflow flag
//  nf     out    1      negative flag: result[WIDTH-1]
//  vf     out    1      signed overflow flag
//  bus    inout  WIDTH  shared bus; result when oe=1, else high-Z
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; result, zf, cf, nf, vf, busy and done all 0.
//    Reset mid-operation aborts the op: no done pulse, partial result discarded.
//  - Bus: bus = oe ? result : 'z. Combinational from the result register, independent of state.
//    While busy, the bus shows the previous result.
//  - Start capture: start=1 in IDLE at edge k latches op, fe, a, b. start while busy is ignored.
//    a/b may change freely after edge k.
//  - Single-cycle ops (ADD..XOR; MUL when MUL_EN=0): result and flags written at edge k.
//    done=1 during cycle k..k+1; busy stays 0.
//  - SHL/SHR: shift count n = b[$clog2(WIDTH)-1:0].
//    - n=0: completes like a single-cycle op; result=a, cf=0.
//    - n>0: states IDLE->SHIFT. busy=1 from edge k; one bit shifted per cycle; zero-fill.
//    - Completion at edge k+n: result written, busy->0, done pulse, back to IDLE.
//    - cf = last bit shifted out.
//  - MUL (MUL_EN=1): states IDLE->MUL; shift-add over WIDTH cycles.
//    - Completion at edge k+WIDTH: result = low WIDTH bits of a*b (unsigned).
//    - cf=1 iff the high WIDTH bits are nonzero; vf=0.
//  - Arithmetic is computed at WIDTH+1 bits.
//    - ADD: cf = carry out.
//    - SUB: result = a-b mod 2^WIDTH; cf = borrow (a<b unsigned).
//    - vf, ADD: operand signs equal and result sign differs.
//    - vf, SUB: operand signs differ and result sign differs from a.
//    - Logic ops: cf=0, vf=0. Shifts: vf=0.
//  - Flags: zf = (result==0); nf = result MSB.
//    All four flags update only at completion and only if the latched fe=1.
//    If fe=0, flags hold while result still updates.
//  - done is high for exactly one cycle per accepted start.
//    A new start is accepted in the cycle after done: back-to-back single-cycle ops give one result per cycle.
// TESTING
//  1 WIDTH=8, ADD a=8'hF0 b=8'h10 fe=1 -> edge after start: result 0, zf=1, cf=1, vf=0, done one cycle, busy 0.
//  2 SUB a=8'h05 b=8'h07 -> result 8'hFE, cf=1, nf=1, zf=0.
//    SUB a=8'h80 b=8'h01 -> result 8'h7F, vf=1.
//  3 SHL a=8'h81 b=3 -> busy 3 cycles, done at edge k+3, result 8'h08, cf=0.
//    SHR a=8'h01 b=1 -> result 0, cf=1, zf=1.
//  4 MUL a=8'd20 b=8'd13 -> done at edge k+8, result 8'h04 (260 mod 256), cf=1.
//    start pulsed while busy is ignored (exactly one done).
//  5 Reset asserted mid-MUL -> busy/done/result/flags 0 immediately (async), no done pulse.
//    Next start executes normally.
//  6 AND with fe=0 after flags set -> result updates, flags unchanged.
//    oe=0 -> bus high-Z; oe=1 -> bus equals result.

Source files
------------

// File: rtl/alu_seq_module.sv
// alu_seq_module: parametrised sequential ALU for the SAP-style CPU.
// Single-cycle ADD/SUB/AND/OR/XOR, iterative SHL/SHR (one bit per cycle)
// and an optional shift-add multiplier, with a start/busy/done handshake,
// registered result and Z/C/N/V flags, and a tri-state drive onto the bus.
module alu_seq_module #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             fe,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic             zf,
    output logic             cf,
    output logic             nf,
    output logic             vf,
    inout  logic [WIDTH-1:0] bus
);

    localparam int unsigned NW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_MUL   = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t               state, state_nx;
    op_t                  op_in;

    // registered outputs
    logic [WIDTH-1:0]     result;

    // operands/control latched at start for multi-cycle ops
    logic                 shl_q;
    logic                 fe_q;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     sh_reg;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;

    // combinational datapath
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [NW-1:0]        n_in;
    logic [WIDTH-1:0]     sh_nx;
    logic                 sh_out;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_nx;

    // completion controls from the FSM
    logic                 accept;
    logic                 fin;
    logic                 flag_en;
    logic [WIDTH-1:0]     res_nx;
    logic                 cf_nx;
    logic                 vf_nx;

    assign op_in = op_t'(op);
    assign n_in  = b[NW-1:0];
    assign busy  = (state != S_IDLE);
    assign bus   = oe ? result : 'z;

    // Arithmetic at WIDTH+1 bits, one shift step and one shift-add step.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        sh_nx  = '0;
        sh_out = 1'b0;
        if (shl_q) begin
            sh_nx  = {sh_reg[WIDTH-2:0], 1'b0};
            sh_out = sh_reg[WIDTH-1];
        end else begin
            sh_nx  = {1'b0, sh_reg[WIDTH-1:1]};
            sh_out = sh_reg[0];
        end
        addend = mplier[0] ? mcand : '0;
        acc_nx = acc + addend;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, and the result/flag values to write at completion.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        fin      = 1'b0;
        flag_en  = 1'b0;
        res_nx   = '0;
        cf_nx    = 1'b0;
        vf_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    fin     = 1'b1;
                    flag_en = fe;
                    case (op_in)
                        OP_ADD: begin
                            res_nx = sum[WIDTH-1:0];
                            cf_nx  = sum[WIDTH];
                            vf_nx  = (a[WIDTH-1] == b[WIDTH-1]) &&
                                     (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res_nx = diff[WIDTH-1:0];
                            cf_nx  = diff[WIDTH];
                            vf_nx  = (a[WIDTH-1] != b[WIDTH-1]) &&
                                     (diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND: res_nx = a & b;
                        OP_OR:  res_nx = a | b;
                        OP_XOR: res_nx = a ^ b;
                        OP_SHL, OP_SHR: begin
                            // zero shift count completes immediately with a
                            if (n_in != '0) begin
                                fin      = 1'b0;
                                state_nx = S_SHIFT;
                            end else begin
                                res_nx = a;
                            end
                        end
                        OP_MUL: begin
                            if (MUL_EN) begin
                                fin      = 1'b0;
                                state_nx = S_MUL;
                            end
                        end
                        default: res_nx = '0;
                    endcase
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_ONE) begin
                    fin      = 1'b1;
                    flag_en  = fe_q;
                    res_nx   = sh_nx;
                    cf_nx    = sh_out;
                    state_nx = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt == CNT_ONE) begin
                    fin      = 1'b1;
                    flag_en  = fe_q;
                    res_nx   = acc_nx[WIDTH-1:0];
                    cf_nx    = |acc_nx[2*WIDTH-1:WIDTH];
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Result/flag registers, done pulse and multi-cycle working registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            nf     <= 1'b0;
            vf     <= 1'b0;
            done   <= 1'b0;
            shl_q  <= 1'b0;
            fe_q   <= 1'b0;
            cnt    <= '0;
            sh_reg <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
        end else begin
            done <= fin;
            if (fin) begin
                result <= res_nx;
                if (flag_en) begin
                    zf <= (res_nx == '0);
                    nf <= res_nx[WIDTH-1];
                    cf <= cf_nx;
                    vf <= vf_nx;
                end
            end
            if (accept) begin
                shl_q  <= (op_in == OP_SHL);
                fe_q   <= fe;
                sh_reg <= a;
                cnt    <= (op_in == OP_MUL) ? CW'(WIDTH) : CW'(n_in);
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
            end else if (state == S_SHIFT) begin
                sh_reg <= sh_nx;
                cnt    <= cnt - CNT_ONE;
            end else if (state == S_MUL) begin
                acc    <= acc_nx;
                mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                cnt    <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_module.sv
// Directed testbench for alu_seq_module at WIDTH=8 with the multiplier present.
module tb_alu_seq_module;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic       fe;
    logic [7:0] a;
    logic [7:0] b;
    logic       oe;
    logic       busy, done, zf, cf, nf, vf;
    wire  [7:0] bus;

    int checks = 0;
    int errors = 0;
    int ndone;
    int dstep;

    alu_seq_module #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .fe(fe), .a(a), .b(b),
        .oe(oe), .busy(busy), .done(done), .zf(zf), .cf(cf), .nf(nf), .vf(vf),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at the falling edge; return 1 ns after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic f);
        @(negedge clk);
        op = o; a = aa; b = bb; fe = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~aa;
        b = ~bb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic z, input logic c,
                         input logic n, input logic v);
        chk({tag, "_zf"}, 32'(zf), 32'(z));
        chk({tag, "_cf"}, 32'(cf), 32'(c));
        chk({tag, "_nf"}, 32'(nf), 32'(n));
        chk({tag, "_vf"}, 32'(vf), 32'(v));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = '0; fe = 1'b0; a = '0; b = '0; oe = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bus", 32'(bus), 0);
        flags("rst", 0, 0, 0, 0);
        #1 rst = 1'b1;

        issue(ADD, 8'hF0, 8'h10, 1'b1);
        chk("add_bus", 32'(bus), 32'h00);
        chk("add_done", 32'(done), 1);
        chk("add_busy", 32'(busy), 0);
        flags("add", 1, 1, 0, 0);
        step();
        chk("add_done_pulse", 32'(done), 0);

        issue(SUB, 8'h05, 8'h07, 1'b1);
        chk("sub1_bus", 32'(bus), 32'hFE);
        flags("sub1", 0, 1, 1, 0);
        issue(SUB, 8'h80, 8'h01, 1'b1);
        chk("sub2_b2b_done", 32'(done), 1);
        chk("sub2_bus", 32'(bus), 32'h7F);
        flags("sub2", 0, 0, 0, 1);
        issue(ADD, 8'h7F, 8'h01, 1'b1);
        chk("addv_bus", 32'(bus), 32'h80);
        flags("addv", 0, 0, 1, 1);
        issue(XOR_, 8'hA5, 8'hFF, 1'b1);
        chk("xor_bus", 32'(bus), 32'h5A);
        flags("xor", 0, 0, 0, 0);
        step();

        issue(SHL, 8'h81, 8'h03, 1'b1);
        chk("shl_busy0", 32'(busy), 1);
        chk("shl_done0", 32'(done), 0);
        chk("shl_prev_bus", 32'(bus), 32'h5A);
        step();
        step();
        chk("shl_busy2", 32'(busy), 1);
        chk("shl_done2", 32'(done), 0);
        step();
        chk("shl_busy3", 32'(busy), 0);
        chk("shl_done3", 32'(done), 1);
        chk("shl_bus", 32'(bus), 32'h08);
        flags("shl", 0, 0, 0, 0);

        issue(SHR, 8'h01, 8'h01, 1'b1);
        chk("shr_busy0", 32'(busy), 1);
        step();
        chk("shr_done", 32'(done), 1);
        chk("shr_bus", 32'(bus), 32'h00);
        flags("shr", 1, 1, 0, 0);

        issue(SHL, 8'h5A, 8'h08, 1'b1);
        chk("shl0_busy", 32'(busy), 0);
        chk("shl0_done", 32'(done), 1);
        chk("shl0_bus", 32'(bus), 32'h5A);
        flags("shl0", 0, 0, 0, 0);

        issue(MUL, 8'd20, 8'd13, 1'b1);
        chk("mul_busy0", 32'(busy), 1);
        ndone = 0;
        dstep = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 3) begin
                start = 1'b1; op = ADD; a = 8'h01; b = 8'h01; fe = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                dstep = i;
            end
        end
        chk("mul_ndone", 32'(ndone), 1);
        chk("mul_dstep", 32'(dstep), 8);
        chk("mul_bus", 32'(bus), 32'h04);
        chk("mul_busy_end", 32'(busy), 0);
        flags("mul", 0, 1, 0, 0);

        issue(MUL, 8'h03, 8'h03, 1'b1);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_bus", 32'(bus), 0);
        flags("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) ndone++;
        end
        chk("arst_nodone", 32'(ndone), 0);
        chk("arst_bus_after", 32'(bus), 0);
        issue(ADD, 8'h02, 8'h03, 1'b1);
        chk("post_rst_done", 32'(done), 1);
        chk("post_rst_bus", 32'(bus), 32'h05);

        issue(SUB, 8'h05, 8'h07, 1'b1);
        flags("fe_set", 0, 1, 1, 0);
        issue(AND_, 8'h0F, 8'hF0, 1'b0);
        chk("and_bus", 32'(bus), 32'h00);
        flags("and_hold", 0, 1, 1, 0);
        issue(OR_, 8'h0F, 8'h30, 1'b0);
        chk("or_bus", 32'(bus), 32'h3F);
        flags("or_hold", 0, 1, 1, 0);
        step();
        oe = 1'b0;
        #1;
        chk("oe0_released", 32'(bus !== 8'h3F), 1);
        oe = 1'b1;
        #1;
        chk("oe1_bus", 32'(bus), 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
